// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC and talks to a variable-latency instruction memory.
// It feeds IF/ID and squashes wrong-path fetches. Define FETCH_PERF_CNT_EN for the fetch/bubble counters.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] output_instruction,
  output logic [31:0] output_next_address,
  output logic        output_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buffer_r;
  logic [31:0] saved_target_r;

  logic        redir_s;
  logic [31:0] target_s;
  logic [31:0] pc_seq_s;

  // Redirect selection: branch wins, targets forced word-aligned.
  always_comb begin
    redir_s  = branch_taken | jump;
    target_s = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    pc_seq_s = pc_r + PC_STEP;
  end

  // Stage outputs; any redirect cycle presents a bubble.
  always_comb begin
    imem_req            = 1'b0;
    imem_addr           = pc_r;
    output_valid        = 1'b0;
    output_instruction  = NOP_INSTR;
    output_next_address = pc_seq_s;
    case (state_r)
      RST_IDLE: begin
        imem_req     = 1'b0;
        output_valid = 1'b0;
      end
      FETCH: begin
        imem_req     = 1'b1;
        output_valid = imem_ready & ~redir_s;
        if (imem_ready && !redir_s) begin
          output_instruction = imem_rdata;
        end else begin
          output_instruction = NOP_INSTR;
        end
      end
      BUFFERED: begin
        imem_req     = 1'b0;
        output_valid = ~redir_s;
        if (!redir_s) begin
          output_instruction = buffer_r;
        end else begin
          output_instruction = NOP_INSTR;
        end
      end
      DRAIN: begin
        imem_req     = 1'b1;
        output_valid = 1'b0;
      end
      default: begin
        imem_req     = 1'b0;
        output_valid = 1'b0;
      end
    endcase
  end

  // Fetch FSM: PC, hold buffer and the redirect target saved across a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= RST_IDLE;
      pc_r           <= RESET_PC;
      buffer_r       <= NOP_INSTR;
      saved_target_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        RST_IDLE: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            if (redir_s) begin
              pc_r <= target_s;
            end else if (!hold) begin
              pc_r <= pc_seq_s;
            end else begin
              buffer_r <= imem_rdata;
              state_r  <= BUFFERED;
            end
          end else if (redir_s) begin
            // The request must complete before the redirect can take effect.
            saved_target_r <= target_s;
            state_r        <= DRAIN;
          end else begin
            state_r <= FETCH;
          end
        end
        BUFFERED: begin
          if (redir_s) begin
            pc_r    <= target_s;
            state_r <= FETCH;
          end else if (!hold) begin
            pc_r    <= pc_seq_s;
            state_r <= FETCH;
          end else begin
            state_r <= BUFFERED;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            pc_r    <= redir_s ? target_s : saved_target_r;
            state_r <= FETCH;
          end else if (redir_s) begin
            saved_target_r <= target_s;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= RST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic in_mem_state_s;

  // Bubbles are only counted while the stage is actively requesting.
  always_comb begin
    in_mem_state_s = (state_r == FETCH) || (state_r == DRAIN);
  end

  // Free-running wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= 32'h0000_0000;
      bubble_count <= 32'h0000_0000;
    end else begin
      if (output_valid && !hold) begin
        fetch_count <= fetch_count + 32'd1;
      end else begin
        fetch_count <= fetch_count;
      end
      if (in_mem_state_s && !output_valid) begin
        bubble_count <= bubble_count + 32'd1;
      end else begin
        bubble_count <= bubble_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: memory returns addr+0x100, expected outputs are queued per fetch.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] output_instruction;
  logic [31:0] output_next_address;
  logic        output_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
  logic [31:0] fetch_model;
  logic [31:0] bubble_model;
`endif

  int n_checks;
  int n_pass;
  logic [63:0] exp_q[$];

  instr_fetch_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .hold                (hold),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .jump                (jump),
    .jump_target         (jump_target),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ready          (imem_ready),
    .imem_rdata          (imem_rdata),
    .output_instruction  (output_instruction),
    .output_next_address (output_next_address),
    .output_valid        (output_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count         (fetch_count),
    .bubble_count        (bubble_count)
`endif
  );

  assign imem_rdata = imem_addr + 32'h0000_0100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] next);
    exp_q.push_back({instr, next});
  endtask

  // One clock cycle: drive inputs, sample on the falling edge, then step past the rising edge.
  task automatic cyc(input logic h, input logic br, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic rdy, input logic exp_req,
                     input logic [31:0] exp_addr, input logic exp_valid);
    logic [63:0] e;
    hold = h; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = rdy;
    @(negedge clk);
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check_eq("imem_addr", imem_addr, exp_addr);
    check_eq("next_address", output_next_address, exp_addr + 32'd4);
    check_eq("valid", {31'd0, output_valid}, {31'd0, exp_valid});
    if (output_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid_instr", output_instruction, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_instruction", output_instruction, e[63:32]);
        check_eq("sb_next_address", output_next_address, e[31:0]);
      end
    end else begin
      check_eq("bubble_nop", output_instruction, 32'h0000_0000);
    end
`ifdef FETCH_PERF_CNT_EN
    check_eq("fetch_count", fetch_count, fetch_model);
    check_eq("bubble_count", bubble_count, bubble_model);
    if (exp_valid && !h) fetch_model = fetch_model + 32'd1;
    if (exp_req && !exp_valid) bubble_model = bubble_model + 32'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0000_0000);
    check_eq("rst_next", output_next_address, 32'h0000_0004);
    check_eq("rst_valid", {31'd0, output_valid}, 32'd0);
    check_eq("rst_instr", output_instruction, 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_fetch_count", fetch_count, 32'd0);
    check_eq("rst_bubble_count", bubble_count, 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; hold = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0; imem_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    fetch_model = 32'd0; bubble_model = 32'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // RST_IDLE cycle, then sequential fetches
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    push_exp(32'h100, 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0, 1'b1);
    push_exp(32'h104, 32'h8);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h4, 1'b1);
    // memory wait states at pc=8
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8, 1'b0);
    push_exp(32'h108, 32'hC);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 1'b1);
    // hold: FETCH -> BUFFERED, held, then release
    push_exp(32'h10C, 32'h10);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 1'b1);
    push_exp(32'h10C, 32'h10);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hC, 1'b1);
    push_exp(32'h10C, 32'h10);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hC, 1'b1);
    push_exp(32'h110, 32'h14);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 1'b1);
    // simultaneous branch/jump: branch wins, target aligned
    cyc(1'b0, 1'b1, 32'h203, 1'b1, 32'h400, 1'b1, 1'b1, 32'h14, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h24, 1'b1, 1'b1, 32'h200, 1'b0);
    // redirect while pending -> DRAIN, old address held, data discarded
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h24, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h24, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h24, 1'b0);
    push_exp(32'h140, 32'h44);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 1'b1);
    // second redirect during DRAIN overwrites the saved target
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h44, 1'b0);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h44, 1'b0);
    push_exp(32'h1C0, 32'hC4);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hC0, 1'b1);
    // top-of-address-space wrap of next_address
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hC4, 1'b0);
    cyc(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    push_exp(32'h110, 32'h14);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 1'b1);

    // asynchronous reset mid-operation, pc=0x14 with a request outstanding
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
`ifdef FETCH_PERF_CNT_EN
    fetch_model = 32'd0; bubble_model = 32'd0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    push_exp(32'h100, 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0, 1'b1);

    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
